matrix_cursor_ctrl: RTL

Sequential controller that drives the column/row coordinate inputs (mdc, mdl) of the 1-of-36 cell-select decoder from five push buttons. It moves a cursor over a 6x6 cell grid with wrap-around and toggles a 36-bit cell-mark register at the decoder's select index on OK. It also provides a cursor blink strobe for the display path, and sits between the board buttons and the decoder/display logic.

---
 rtl/matrix_cursor_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/matrix_cursor_ctrl.sv
// Push-button cursor controller for a 6x6 cell grid: debounces five buttons, moves the
// decoder coordinates (mdc/mdl) with wrap-around and toggles the mark bit chosen by the decoder.
module matrix_cursor_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int BLINK_CYCLES    = 64,
    parameter int COLS            = 6,
    parameter int ROWS            = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_up_n,
    input  logic        btn_down_n,
    input  logic        btn_left_n,
    input  logic        btn_right_n,
    input  logic        btn_ok_n,
    input  logic [5:0]  sel_in,
    output logic [2:0]  mdc,
    output logic [2:0]  mdl,
    output logic [35:0] mark,
    output logic        blink,
    output logic        commit,
    output logic        sel_err,
    output logic        busy
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int BL_W = $clog2(BLINK_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_CYCLES - 1);
    localparam logic [2:0] COLS_L = 3'(COLS);
    localparam logic [2:0] ROWS_L = 3'(ROWS);

    typedef enum logic [1:0] {S_IDLE, S_MOVE, S_COMMIT, S_WAIT_REL} state_t;
    typedef enum logic [1:0] {D_UP, D_DOWN, D_LEFT, D_RIGHT} dir_t;

    // Button vector index: 0 up, 1 down, 2 left, 3 right, 4 ok. Levels are active-low (1 = released).
    logic [4:0]            btn_raw;
    logic [4:0]            sync1_q, sync2_q, level_q, level_d, press_q, press_d;
    logic [4:0][DB_W-1:0]  cnt_q, cnt_d;
    state_t                state_q, state_d;
    dir_t                  dir_q, dir_d;
    logic [2:0]            mdc_q, mdc_d, mdl_q, mdl_d;
    logic [35:0]           mark_q, mark_d;
    logic                  commit_q, commit_d, sel_err_q, sel_err_d;
    logic                  blink_q, blink_d;
    logic [BL_W-1:0]       blink_cnt_q, blink_cnt_d;

    assign btn_raw = {btn_ok_n, btn_right_n, btn_left_n, btn_down_n, btn_up_n};

    function automatic logic [2:0] dec_wrap(input logic [2:0] v, input logic [2:0] lim);
        if (v == 3'd0)     return lim - 3'd1;
        else if (v >= lim) return 3'd0;
        else               return v - 3'd1;
    endfunction

    function automatic logic [2:0] inc_wrap(input logic [2:0] v, input logic [2:0] lim);
        if (v >= lim - 3'd1) return 3'd0;
        else                 return v + 3'd1;
    endfunction

    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        press_d = '0;
        for (int i = 0; i < 5; i++) begin
            if (sync2_q[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == DB_LAST) begin
                level_d[i] = sync2_q[i];
                cnt_d[i]   = '0;
                press_d[i] = ~sync2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + DB_W'(1);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        mdc_d     = mdc_q;
        mdl_d     = mdl_q;
        mark_d    = mark_q;
        commit_d  = 1'b0;
        sel_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (press_q[4])      state_d = S_COMMIT;
                else if (press_q[0]) begin dir_d = D_UP;    state_d = S_MOVE; end
                else if (press_q[1]) begin dir_d = D_DOWN;  state_d = S_MOVE; end
                else if (press_q[2]) begin dir_d = D_LEFT;  state_d = S_MOVE; end
                else if (press_q[3]) begin dir_d = D_RIGHT; state_d = S_MOVE; end
            end
            S_MOVE: begin
                case (dir_q)
                    D_UP:    mdl_d = dec_wrap(mdl_q, ROWS_L);
                    D_DOWN:  mdl_d = inc_wrap(mdl_q, ROWS_L);
                    D_LEFT:  mdc_d = dec_wrap(mdc_q, COLS_L);
                    default: mdc_d = inc_wrap(mdc_q, COLS_L);
                endcase
                state_d = S_WAIT_REL;
            end
            S_COMMIT: begin
                // sel_in is settled here: the cursor last changed at least one cycle earlier.
                if (sel_in < 6'd36) begin
                    mark_d   = mark_q ^ (36'd1 << sel_in);
                    commit_d = 1'b1;
                end else begin
                    sel_err_d = 1'b1;
                end
                state_d = S_WAIT_REL;
            end
            default: begin
                if (&level_q) state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        blink_d     = blink_q;
        blink_cnt_d = blink_cnt_q + BL_W'(1);
        if (state_q == S_MOVE) begin
            blink_d     = 1'b1;
            blink_cnt_d = '0;
        end else if (blink_cnt_q == BL_LAST) begin
            blink_d     = ~blink_q;
            blink_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= '1;
            sync2_q     <= '1;
            level_q     <= '1;
            cnt_q       <= '0;
            press_q     <= '0;
            state_q     <= S_IDLE;
            dir_q       <= D_UP;
            mdc_q       <= '0;
            mdl_q       <= '0;
            mark_q      <= '0;
            commit_q    <= 1'b0;
            sel_err_q   <= 1'b0;
            blink_q     <= 1'b0;
            blink_cnt_q <= '0;
        end else begin
            sync1_q     <= btn_raw;
            sync2_q     <= sync1_q;
            level_q     <= level_d;
            cnt_q       <= cnt_d;
            press_q     <= press_d;
            state_q     <= state_d;
            dir_q       <= dir_d;
            mdc_q       <= mdc_d;
            mdl_q       <= mdl_d;
            mark_q      <= mark_d;
            commit_q    <= commit_d;
            sel_err_q   <= sel_err_d;
            blink_q     <= blink_d;
            blink_cnt_q <= blink_cnt_d;
        end
    end

    assign mdc     = mdc_q;
    assign mdl     = mdl_q;
    assign mark    = mark_q;
    assign blink   = blink_q;
    assign commit  = commit_q;
    assign sel_err = sel_err_q;
    assign busy    = (state_q != S_IDLE);

endmodule
